fpam_rbuf: RTL and testbench

FPAM_RBUF -- requirements
Module: fpam_rbuf

---
 rtl/fpam_rbuf.sv | 95 +++++++++
 tb/tb_fpam_rbuf.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fpam_rbuf.sv
// Result FIFO between the fpam datapath (no backpressure) and a stallable consumer.
// Head entry is shown combinationally and classified; drops and NaN results are tracked.
module fpam_rbuf #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pushin,
    input  logic [63:0]              z,
    input  logic                     stopin,
    output logic                     pushout,
    output logic [63:0]              zout,
    output logic [2:0]               zclass,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic [15:0]              nancnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   nancnt_q, nancnt_d;
    logic          pop, push, full, z_is_nan;
    logic [10:0]   head_exp;
    logic [51:0]   head_frac;

    assign full     = (count_q == FULL_CNT);
    assign pushout  = (count_q != '0);
    assign pop      = pushout && !stopin;
    // A full buffer still accepts a word when the head leaves in the same cycle.
    assign push     = pushin && !rst && (!full || pop);
    assign z_is_nan = (z[62:52] == 11'h7FF) && (z[51:0] != 52'd0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        nancnt_d = nancnt_q;
        if (push)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
        if (pushin && full && !pop)
            ovf_d = 1'b1;
        if (push && z_is_nan && (nancnt_q != 16'hFFFF))
            nancnt_d = nancnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            nancnt_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            nancnt_q <= nancnt_d;
        end
    end

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= z;
    end

    assign zout      = mem_q[rd_ptr_q];
    assign head_exp  = zout[62:52];
    assign head_frac = zout[51:0];

    always_comb begin
        zclass = 3'd0;
        if (head_exp == 11'h7FF)
            zclass = (head_frac != 52'd0) ? 3'd4 : 3'd3;
        else if (head_exp == 11'h000)
            zclass = (head_frac != 52'd0) ? 3'd2 : 3'd1;
    end

    assign count  = count_q;
    assign ovf    = ovf_q;
    assign nancnt = nancnt_q;
endmodule

// File: tb/tb_fpam_rbuf.sv
// Directed and random scoreboard bench for fpam_rbuf.
module tb_fpam_rbuf;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        pushin;
    logic [63:0] z;
    logic        stopin;
    logic        pushout;
    logic [63:0] zout;
    logic [2:0]  zclass;
    logic [3:0]  count;
    logic        ovf;
    logic [15:0] nancnt;

    int tests = 0;
    int fails = 0;

    logic [63:0] sb_q [$];
    logic        exp_ovf;
    logic [15:0] exp_nan;

    fpam_rbuf #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pushin(pushin), .z(z), .stopin(stopin),
        .pushout(pushout), .zout(zout), .zclass(zclass), .count(count),
        .ovf(ovf), .nancnt(nancnt)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] cls(input logic [63:0] v);
        if (v[62:52] == 11'h7FF) return (v[51:0] == 0) ? 3'd3 : 3'd4;
        if (v[62:52] == 11'h000) return (v[51:0] == 0) ? 3'd1 : 3'd2;
        return 3'd0;
    endfunction

    function automatic logic is_nan(input logic [63:0] v);
        return (v[62:52] == 11'h7FF) && (v[51:0] != 0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, check/update the model at negedge, return 1ns after posedge.
    task automatic cycle(input logic pi, input logic [63:0] zi, input logic si);
        logic [63:0] head;
        logic        do_pop;
        pushin = pi;
        z      = zi;
        stopin = si;
        @(negedge clk);
        chk("count",   64'(count),   64'(sb_q.size()));
        chk("pushout", 64'(pushout), 64'(sb_q.size() != 0));
        chk("ovf",     64'(ovf),     64'(exp_ovf));
        chk("nancnt",  64'(nancnt),  64'(exp_nan));
        tests++;
        assert (count <= DEPTH) else begin
            fails++;
            $error("FAIL count_bound observed=%0d expected<=%0d", count, DEPTH);
        end
        do_pop = (sb_q.size() != 0) && !si;
        if (do_pop) begin
            head = sb_q.pop_front();
            chk("zout",   zout,          head);
            chk("zclass", 64'(zclass),   64'(cls(head)));
        end
        if (pi) begin
            if (sb_q.size() < DEPTH) begin
                sb_q.push_back(zi);
                if (is_nan(zi) && exp_nan != 16'hFFFF) exp_nan++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        pushin = 1'b1;
        z      = {$urandom, $urandom};
        stopin = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        exp_ovf = 1'b0;
        exp_nan = '0;
    endtask

    initial begin
        logic [63:0] rv;
        int          gap;
        sb_q.delete();
        exp_ovf = 1'b0;
        exp_nan = '0;
        rst = 1'b1; pushin = 1'b0; z = '0; stopin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("reset_pushout", 64'(pushout), 64'd0);
        chk("reset_count",   64'(count),   64'd0);

        // Single word latency: visible right after the push edge, gone after the pop.
        cycle(1'b1, 64'h3FF0000000000000, 1'b0);
        chk("lat_pushout", 64'(pushout), 64'd1);
        chk("lat_zout",    zout,         64'h3FF0000000000000);
        chk("lat_zclass",  64'(zclass),  64'd0);
        cycle(1'b0, 'x, 1'b0);
        chk("lat_empty",   64'(pushout), 64'd0);

        // Overflow: nine words into a stalled buffer.
        for (int i = 1; i <= 9; i++) cycle(1'b1, 64'(i), 1'b1);
        chk("ovf_count", 64'(count), 64'd8);
        chk("ovf_flag",  64'(ovf),   64'd1);
        chk("ovf_head",  zout,       64'd1);
        for (int i = 0; i < 9; i++) cycle(1'b0, {$urandom, $urandom}, 1'b0);
        chk("ovf_sticky", 64'(ovf),  64'd1);
        chk("ovf_drain",  64'(count), 64'd0);

        // Classification and NaN counting.
        cycle(1'b1, 64'h0000000000000000, 1'b1);
        cycle(1'b1, 64'h8000000000000001, 1'b1);
        cycle(1'b1, 64'h7FF0000000000000, 1'b1);
        cycle(1'b1, 64'h7FF8000000000000, 1'b1);
        chk("nan_one", 64'(nancnt), 64'd1);
        cycle(1'b1, 64'h4000000000000000, 1'b1);
        chk("pre_rst_count", 64'(count), 64'd5);

        // Reset mid-operation.
        do_reset();
        chk("rst_count",   64'(count),   64'd0);
        chk("rst_pushout", 64'(pushout), 64'd0);
        chk("rst_ovf",     64'(ovf),     64'd0);
        chk("rst_nancnt",  64'(nancnt),  64'd0);

        // Classes delivered in order.
        cycle(1'b1, 64'h0000000000000000, 1'b1);
        cycle(1'b1, 64'h8000000000000001, 1'b1);
        cycle(1'b1, 64'h7FF0000000000000, 1'b1);
        cycle(1'b1, 64'h7FF8000000000000, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 'x, 1'b0);

        // Full buffer with simultaneous push and pop.
        for (int i = 0; i < 8; i++) cycle(1'b1, 64'(16'hA0 + i), 1'b1);
        cycle(1'b1, 64'h00000000000000FF, 1'b0);
        chk("full_pp_count", 64'(count), 64'd8);
        chk("full_pp_ovf",   64'(ovf),   64'd0);
        for (int i = 0; i < 9; i++) cycle(1'b0, 'x, 1'b0);

        // Random stream against the scoreboard.
        for (int n = 0; n < 1800; n++) begin
            gap = $urandom_range(0, 15);
            for (int g = 0; g < gap; g++)
                cycle(1'b0, {$urandom, $urandom}, ($urandom_range(0, 2) == 0));
            case ($urandom_range(0, 7))
                0: rv = {$urandom_range(0, 1) == 1, 11'h7FF, 52'd0};
                1: rv = {1'b0, 11'h7FF, 20'($urandom) | 20'd1, 32'($urandom)};
                2: rv = {$urandom_range(0, 1) == 1, 63'd0};
                3: rv = {1'b1, 11'h000, 20'($urandom), 32'($urandom) | 32'd1};
                default: rv = {$urandom, $urandom};
            endcase
            cycle(1'b1, rv, ($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, 'x, 1'b0);
        chk("final_empty", 64'(count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
